// File: rtl/cpu_rst_ctrl_pkg.sv
// Shared definitions for the CPU reset controller: channel FSM state
// encoding and the reset-cause codes reported on cause_o.
package cpu_rst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_POR      = 2'd0,
    ST_RUN      = 2'd1,
    ST_DBG_HOLD = 2'd2,
    ST_STRETCH  = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_DBG = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;
  localparam logic [1:0] CAUSE_WDT = 2'd3;

endpackage

// File: rtl/cpu_rst_ctrl_chan.sv
// One CPU reset channel: power-on hold, debug hold, software/watchdog
// stretched resets. The watchdog exists only when CPU_RST_CTRL_WDT_EN
// is defined; otherwise wdt_kick_i is ignored and cause WDT never occurs.
module cpu_rst_ctrl_chan
  import cpu_rst_ctrl_pkg::*;
#(
  parameter int POR_CYCLES     = 16,
  parameter int STRETCH_CYCLES = 8,
  parameter int WDT_LIMIT      = 50000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dbg_run_i,
  input  logic       sw_rst_i,
  input  logic       wdt_kick_i,
  output logic       rst_cpu_o,
  output logic       armed_o,
  output logic [1:0] cause_o
);

  localparam int POR_W = $clog2(POR_CYCLES + 1);
  localparam int STR_W = $clog2(STRETCH_CYCLES + 1);

  state_e           state_q, state_d;
  logic [POR_W-1:0] por_q, por_d;
  logic [STR_W-1:0] str_q, str_d;
  logic [1:0]       cause_q, cause_d;
  logic             armed_q, armed_d;
  logic             rst_q, rst_d;
  logic             dbg_stop;
  logic             wdt_expire;

  // A debug stop only counts once the bridge has shown it is alive.
  assign dbg_stop = armed_q && !dbg_run_i;

`ifdef CPU_RST_CTRL_WDT_EN
  localparam int WDT_W = $clog2(WDT_LIMIT + 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;

  // Watchdog: counts un-kicked RUN cycles, fires on the cycle the count reaches the limit.
  always_comb begin
    wdt_expire = (state_q == ST_RUN) && !wdt_kick_i &&
                 (wdt_q == WDT_W'(WDT_LIMIT - 1));
    wdt_d      = wdt_q + 1'b1;
    if ((state_q != ST_RUN) || wdt_kick_i || wdt_expire) begin
      wdt_d = '0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  logic unused_wdt_kick;

  assign wdt_expire      = 1'b0;
  assign unused_wdt_kick = wdt_kick_i;
`endif

  // Next-state logic; the reset output is registered from the next state.
  always_comb begin
    state_d = state_q;
    por_d   = por_q;
    str_d   = str_q;
    cause_d = cause_q;
    armed_d = armed_q | dbg_run_i;
    case (state_q)
      ST_POR: begin
        if (por_q == POR_W'(POR_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          por_d = por_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (dbg_stop) begin
          state_d = ST_DBG_HOLD;
          cause_d = CAUSE_DBG;
        end else if (wdt_expire) begin
          state_d = ST_STRETCH;
          str_d   = '0;
          cause_d = CAUSE_WDT;
        end else if (sw_rst_i) begin
          state_d = ST_STRETCH;
          str_d   = '0;
          cause_d = CAUSE_SW;
        end
      end
      ST_DBG_HOLD: begin
        // Releasing from debug still gives the core a full minimum pulse.
        if (dbg_run_i) begin
          state_d = ST_STRETCH;
          str_d   = '0;
        end
      end
      ST_STRETCH: begin
        if (dbg_stop) begin
          state_d = ST_DBG_HOLD;
          cause_d = CAUSE_DBG;
        end else if (sw_rst_i) begin
          str_d = '0;
        end else if (str_q == STR_W'(STRETCH_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          str_d = str_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_POR;
      end
    endcase
    rst_d = (state_d != ST_RUN);
  end

  // Channel FSM and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_POR;
      por_q   <= '0;
      str_q   <= '0;
      cause_q <= CAUSE_POR;
      armed_q <= 1'b0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      por_q   <= por_d;
      str_q   <= str_d;
      cause_q <= cause_d;
      armed_q <= armed_d;
      rst_q   <= rst_d;
    end
  end

  assign rst_cpu_o = rst_q;
  assign armed_o   = armed_q;
  assign cause_o   = cause_q;

endmodule

// File: rtl/cpu_rst_ctrl.sv
// CPU reset controller top: NUM_CPU independent reset channels.
// Define CPU_RST_CTRL_WDT_EN to include a per-channel watchdog.
module cpu_rst_ctrl
  import cpu_rst_ctrl_pkg::*;
#(
  parameter int NUM_CPU        = 1,
  parameter int POR_CYCLES     = 16,
  parameter int STRETCH_CYCLES = 8,
  parameter int WDT_LIMIT      = 50000000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CPU-1:0]   dbg_run_i,
  input  logic [NUM_CPU-1:0]   sw_rst_i,
  input  logic [NUM_CPU-1:0]   wdt_kick_i,
  output logic [NUM_CPU-1:0]   rst_cpu_o,
  output logic [NUM_CPU-1:0]   armed_o,
  output logic [2*NUM_CPU-1:0] cause_o
);

  for (genvar n = 0; n < NUM_CPU; n++) begin : g_chan
    cpu_rst_ctrl_chan #(
      .POR_CYCLES    (POR_CYCLES),
      .STRETCH_CYCLES(STRETCH_CYCLES),
      .WDT_LIMIT     (WDT_LIMIT)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .dbg_run_i (dbg_run_i[n]),
      .sw_rst_i  (sw_rst_i[n]),
      .wdt_kick_i(wdt_kick_i[n]),
      .rst_cpu_o (rst_cpu_o[n]),
      .armed_o   (armed_o[n]),
      .cause_o   (cause_o[2*n +: 2])
    );
  end

endmodule
